fifo_frame_reader: RTL
======================

# fifo_frame_reader

Drain side of the receive sample FIFO. The block waits until the FIFO holds at least one full frame of payload, then reads exactly that many words and emits a framed stream on a valid/ready interface toward the Ethernet/packet layer. Each frame is a sync word, a sequence number, the payload, and a checksum word. It absorbs the FIFO's one-cycle registered read latency and any downstream backpressure without losing or duplicating words.

## Interface
- WD, 16, data word width (FIFO and output)
- DP, 11, width of FIFO usedw
- FRAME_LEN, 64, payload words per frame; legal range 1..2^DP-1
- SYNC, 16'h7F7F, frame sync word (WD bits)

Reset is `rst`, synchronous and active-high. The clock is `clk`.

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- enable  in  1  permits new frames to start; sampled only in IDLE
- fifo_usedw  in  DP  FIFO fill level
- fifo_empty  in  1  FIFO empty flag (used only by the checker, not by control)
- fifo_rdreq  out  1  FIFO read strobe; word appears on fifo_q the next cycle
- fifo_q  in  WD  FIFO read data
- out_data  out  WD  stream word
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts the word when out_valid && out_ready
- out_sof  out  1  qualifies the sync word
- out_eof  out  1  qualifies the checksum word
- frame_cnt  out  16  completed frames, wraps at 2^16

## Operation
- States are IDLE, SYNC, SEQ, PAYLOAD, CSUM.
- **IDLE → SYNC:** when enable=1 and fifo_usedw >= FRAME_LEN. Reads are bounded per frame, so the FIFO can never underflow.
- **SYNC:** drives out_data=SYNC and out_sof=1. On accept, go to SEQ.
- **SEQ:** drives out_data=seq (WD bits). On accept, go to PAYLOAD.
- **PAYLOAD:** emits the head of the skid buffer. After FRAME_LEN accepts, go to CSUM.
- **CSUM:** drives out_data=csum and out_eof=1. On accept: seq+1, frame_cnt+1, csum cleared, go to IDLE.
- **Skid buffer:**
  - 2 entries plus an in-flight flag. fifo_q is captured into the buffer the cycle after fifo_rdreq.
  - fifo_rdreq=1 only in SYNC, SEQ, or PAYLOAD, when reads_issued < FRAME_LEN and (buffered + inflight − pop_this_cycle) < 2.
  - Prefetch may start in SYNC.
- **Checksum:** csum = sum of accepted payload words mod 2^WD. The carry is discarded.
- **Sequence:** seq is WD bits and wraps 2^WD−1 → 0.
- **Counters:** reads_issued and words_sent are DP bits and are cleared on entry to SYNC.
- **Output stability:** while out_valid && !out_ready, out_data, out_sof and out_eof hold stable.
- **enable deasserted mid-frame:** the frame completes normally; no new frame starts.
- **Reset mid-frame:**
  - Next cycle: state IDLE, out_valid=0, buffer and in-flight flag discarded.
  - seq, csum and frame_cnt return to 0.
  - The FIFO is reset by the same rst.

## Timing
- **Reset values:** fifo_rdreq=0, out_valid=0, out_sof=0, out_eof=0, out_data=0, frame_cnt=0, seq=0, state IDLE.
- **Start latency:** when the start condition is true in IDLE at cycle t, out_valid=1 with SYNC at t+1.
- **Throughput:** with out_ready held at 1, the frame is FRAME_LEN+3 consecutive valid cycles with no bubbles between SEQ and PAYLOAD or between payload words.
- **Frame gap:** at least one IDLE cycle (out_valid=0) between frames.
- **Read count:** fifo_rdreq pulses exactly FRAME_LEN times per frame, never in IDLE or CSUM.
- **Buffer bound:** buffered + inflight ≤ 2 in every cycle.

## Test plan
- **Basic frame (FRAME_LEN=4):**
  - Stimulus: FIFO preloaded with 0x0001..0x0004, out_ready=1, enable=1.
  - Response: stream 7F7F, 0000, 0001, 0002, 0003, 0004, 000A over 7 consecutive cycles; out_sof on word 0, out_eof on word 6; frame_cnt=1.
- **Threshold:**
  - Stimulus: usedw=3 with FRAME_LEN=4.
  - Response: no fifo_rdreq and out_valid=0 for 20 cycles. After a 4th write, SYNC appears one cycle after usedw reaches 4.
- **Backpressure:**
  - Stimulus: out_ready toggles 1,0,1,0… through the frame.
  - Response: out_data is unchanged across every stalled cycle; the accepted sequence is identical to the basic-frame test; exactly 4 rdreq pulses; buffered + inflight never exceeds 2.
- **Checksum wrap:**
  - Stimulus: payload 0xFFFF ×4.
  - Response: checksum word 0xFFFC.
- **Back-to-back frames and enable:**
  - Stimulus: 12 words preloaded.
  - Response: three frames with seq 0000, 0001, 0002, each separated by ≥1 idle cycle.
  - Deasserting enable during frame 2 payload: frame 2 completes, frame 3 does not start.
- **Reset mid-payload:**
  - Stimulus: rst asserted after 2 payload words accepted.
  - Response: out_valid=0 the next cycle; seq=0 and frame_cnt=0. After refilling with 4 words, the next frame carries seq 0000.

Source files
------------

// File: rtl/fifo_frame_reader_if.sv
// Framed output stream toward the packet layer.
//   out_data  : stream word
//   out_valid : out_data is valid
//   out_ready : sink accepts the word when out_valid && out_ready
//   out_sof   : marks the sync word (first word of a frame)
//   out_eof   : marks the checksum word (last word of a frame)
// master = frame reader (source), slave = packet layer (sink).
interface fifo_frame_reader_if #(
  parameter int WD = 16
);
  logic [WD-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sof;
  logic          out_eof;

  modport master (
    output out_data,
    output out_valid,
    output out_sof,
    output out_eof,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_sof,
    input  out_eof,
    output out_ready
  );
endinterface

// File: rtl/fifo_frame_reader.sv
// Drain side of the receive sample FIFO. Once the FIFO holds a full frame of
// payload, reads exactly FRAME_LEN words and emits
//   sync word, sequence number, payload x FRAME_LEN, checksum
// on a valid/ready stream. A 2-entry skid buffer plus an in-flight flag
// absorbs the FIFO's one-cycle read latency and downstream backpressure.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   enable      : allows a new frame to start (sampled in IDLE only)
//   fifo_usedw  : FIFO fill level
//   fifo_empty  : FIFO empty flag, only watched by the underflow assertion
//   fifo_rdreq  : FIFO read strobe, data returns on fifo_q next cycle
//   fifo_q      : FIFO read data
//   stream      : framed output stream (master side)
//   frame_cnt   : completed frames, wraps at 2^16
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for enable and a full frame in the FIFO
// SYNC    | presenting the sync word (sof); payload prefetch may start
// SEQ     | presenting the sequence number
// PAYLOAD | presenting the skid-buffer head until FRAME_LEN accepts
// CSUM    | presenting the checksum (eof); on accept, frame is done
module fifo_frame_reader #(
  parameter int            WD        = 16,
  parameter int            DP        = 11,
  parameter int            FRAME_LEN = 64,
  parameter logic [WD-1:0] SYNC      = 16'h7F7F
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [DP-1:0]        fifo_usedw,
  input  logic                 fifo_empty,
  output logic                 fifo_rdreq,
  input  logic [WD-1:0]        fifo_q,
  fifo_frame_reader_if.master  stream,
  output logic [15:0]          frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_SEQ,
    S_PAYLOAD,
    S_CSUM
  } state_t;

  localparam logic [DP-1:0] FLEN   = DP'(FRAME_LEN);
  localparam logic [DP-1:0] FLAST  = DP'(FRAME_LEN - 1);
  localparam logic [DP-1:0] DP_ONE = DP'(1);
  localparam logic [WD-1:0] WD_ONE = WD'(1);

  state_t        state;
  logic [WD-1:0] seq;
  logic [WD-1:0] csum;
  logic [WD-1:0] skid0;
  logic [WD-1:0] skid1;
  logic [1:0]    skid_cnt;
  logic          inflight;
  logic [DP-1:0] reads_issued;
  logic [DP-1:0] words_sent;

  logic          accept;
  logic          pop;
  logic          push;
  logic [1:0]    occ_after_pop;

  // Stream outputs are decoded only from registered state and the skid head,
  // so they never depend combinationally on out_ready and stay stable while
  // stalled.
  always_comb begin
    stream.out_valid = 1'b0;
    stream.out_data  = '0;
    stream.out_sof   = 1'b0;
    stream.out_eof   = 1'b0;
    case (state)
      S_SYNC: begin
        stream.out_valid = 1'b1;
        stream.out_data  = SYNC;
        stream.out_sof   = 1'b1;
      end
      S_SEQ: begin
        stream.out_valid = 1'b1;
        stream.out_data  = seq;
      end
      S_PAYLOAD: begin
        stream.out_valid = (skid_cnt != 2'd0);
        stream.out_data  = skid0;
      end
      S_CSUM: begin
        stream.out_valid = 1'b1;
        stream.out_data  = csum;
        stream.out_eof   = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept = stream.out_valid && stream.out_ready;
  assign pop    = (state == S_PAYLOAD) && (skid_cnt != 2'd0) && stream.out_ready;
  assign push   = inflight;

  // Occupancy seen by the read decision counts the word already in flight
  // and credits a pop happening this cycle, which is what keeps payload
  // words back-to-back with out_ready held high. Never exceeds 3 here, and
  // pop implies skid_cnt >= 1, so 2 bits cannot wrap.
  assign occ_after_pop = skid_cnt + {1'b0, inflight} - {1'b0, pop};

  // The read strobe has to see this cycle's pop, so it is the one output
  // left combinational.
  assign fifo_rdreq = ((state == S_SYNC) || (state == S_SEQ) || (state == S_PAYLOAD)) &&
                      (reads_issued < FLEN) && (occ_after_pop < 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      seq          <= '0;
      csum         <= '0;
      frame_cnt    <= '0;
      skid0        <= '0;
      skid1        <= '0;
      skid_cnt     <= 2'd0;
      inflight     <= 1'b0;
      reads_issued <= '0;
      words_sent   <= '0;
    end else begin
      inflight <= fifo_rdreq;
      if (fifo_rdreq) begin
        reads_issued <= reads_issued + DP_ONE;
      end

      // Skid buffer: skid0 is always the head.
      case ({push, pop})
        2'b10: begin
          if (skid_cnt == 2'd0) skid0 <= fifo_q;
          else                  skid1 <= fifo_q;
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid0    <= skid1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid0 <= fifo_q;
          end else begin
            skid0 <= skid1;
            skid1 <= fifo_q;
          end
        end
        default: ;
      endcase

      case (state)
        S_IDLE: begin
          if (enable && (fifo_usedw >= FLEN)) begin
            state        <= S_SYNC;
            reads_issued <= '0;
            words_sent   <= '0;
          end
        end
        S_SYNC: begin
          if (accept) state <= S_SEQ;
        end
        S_SEQ: begin
          if (accept) state <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (pop) begin
            csum       <= csum + skid0;
            words_sent <= words_sent + DP_ONE;
            if (words_sent == FLAST) state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (accept) begin
            seq       <= seq + WD_ONE;
            frame_cnt <= frame_cnt + 16'd1;
            csum      <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Reads are bounded per frame and gated by usedw at start, so the
      // FIFO must never be read while empty.
      assert (!(fifo_rdreq && fifo_empty));
    end
  end

endmodule
